// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies, FSM state type and an opcode classification helper.
package md_unit_pkg;

    // Operation encodings carried on MD_Op
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_NONE  = 3'd7;

    // Default busy durations in cycles (legal range 1-15)
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the operations that occupy the unit for several cycles
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath of the multiply/divide unit. Produces the HI/LO
// result for mult/multu/div/divu and flags a zero divisor. A single unsigned
// divider serves both div and divu; signed division works on magnitudes and
// fixes the signs afterwards (quotient toward zero, remainder follows the
// dividend), which also yields 0x80000000 / -1 = 0x80000000 rem 0.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_sgn;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Products, shared magnitude divider and result selection
    always_comb begin
        // Low 64 bits of the product of sign-extended operands is the signed product
        w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_prod_u = {32'd0, i_a} * {32'd0, i_b};

        w_sgn   = (i_op == MD_DIV);
        w_mag_a = (w_sgn && i_a[31]) ? (~i_a + 32'd1) : i_a;
        w_mag_b = (w_sgn && i_b[31]) ? (~i_b + 32'd1) : i_b;
        // Substitute 1 for a zero divisor; the result is discarded anyway
        w_den   = (i_b == 32'd0) ? 32'd1 : w_mag_b;
        w_uq    = w_mag_a / w_den;
        w_ur    = w_mag_a % w_den;
        w_q     = (w_sgn && (i_a[31] ^ i_b[31])) ? (~w_uq + 32'd1) : w_uq;
        w_r     = (w_sgn && i_a[31]) ? (~w_ur + 32'd1) : w_ur;

        o_div_zero = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);

        o_hi_res = 32'd0;
        o_lo_res = 32'd0;
        case (i_op)
            MD_MULT: begin
                o_hi_res = w_prod_s[63:32];
                o_lo_res = w_prod_s[31:0];
            end
            MD_MULTU: begin
                o_hi_res = w_prod_u[63:32];
                o_lo_res = w_prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_hi_res = w_r;
                o_lo_res = w_q;
            end
            default: begin
                o_hi_res = 32'd0;
                o_lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit shell for the E stage: owns HI/LO, runs a two-state
// FSM with a down-counter to model the fixed mult/div latency.
// Optional feature: define MD_CANCEL_EN to add the MD_Cancel flush input.
//
// Handshake: MD_Start is a one-cycle pulse sampled at a rising edge (t0).
// In IDLE a mult/div op latches its result at t0, MD_Busy is high for cycles
// t0+1..t0+N and HI/LO update at edge t0+N; mthi/mtlo write at t0 without
// raising busy. MD_Start while busy is ignored (the stall unit prevents it).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CANCEL_EN
    input  logic        MD_Cancel,
`endif
    input  logic        MD_Start,
    input  logic [2:0]  MD_Op,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    output logic        MD_Busy,
    output logic [31:0] MD_HI,
    output logic [31:0] MD_LO
);

    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    md_state_e   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi_tmp;
    logic [31:0] r_lo_tmp;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_state_e   w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_hi_tmp_nxt;
    logic [31:0] w_lo_tmp_nxt;
    logic        w_dz_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;
    logic        w_div_zero;
    logic        w_cancel;

`ifdef MD_CANCEL_EN
    assign w_cancel = MD_Cancel;
`else
    assign w_cancel = 1'b0;
`endif

    md_calc u_calc (
        .i_op       (MD_Op),
        .i_a        (MD_A),
        .i_b        (MD_B),
        .o_hi_res   (w_hi_res),
        .o_lo_res   (w_lo_res),
        .o_div_zero (w_div_zero)
    );

    // Next-state, counter, result latch and HI/LO update decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_tmp_nxt = r_hi_tmp;
        w_lo_tmp_nxt = r_lo_tmp;
        w_dz_nxt     = r_dz;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        case (r_state)
            ST_IDLE: begin
                // A cancel discards any start presented on the same edge
                if (MD_Start && !w_cancel) begin
                    if (md_is_arith(MD_Op)) begin
                        w_hi_tmp_nxt = w_hi_res;
                        w_lo_tmp_nxt = w_lo_res;
                        w_dz_nxt     = w_div_zero;
                        w_cnt_nxt    = md_is_mult(MD_Op) ? LP_MULT_N : LP_DIV_N;
                        w_state_nxt  = ST_BUSY;
                    end else if (MD_Op == MD_MTHI) begin
                        w_hi_nxt = MD_A;
                    end else if (MD_Op == MD_MTLO) begin
                        w_lo_nxt = MD_A;
                    end
                end
            end
            ST_BUSY: begin
                if (w_cancel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    // Final busy edge: commit unless the divisor was zero
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (!r_dz) begin
                        w_hi_nxt = r_hi_tmp;
                        w_lo_nxt = r_lo_tmp;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter, latches and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_dz     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi_tmp <= w_hi_tmp_nxt;
            r_lo_tmp <= w_lo_tmp_nxt;
            r_dz     <= w_dz_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign MD_Busy = (r_state == ST_BUSY);
    assign MD_HI   = r_hi;
    assign MD_LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases from the test plan plus
// randomized operations against a plain-arithmetic HI/LO reference model.
// Define MD_CANCEL_EN to also exercise the cancel input.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk;
    logic        reset;
    logic        MD_Cancel;
    logic        MD_Start;
    logic [2:0]  MD_Op;
    logic [31:0] MD_A;
    logic [31:0] MD_B;
    logic        MD_Busy;
    logic [31:0] MD_HI;
    logic [31:0] MD_LO;

    int n_vec = 0;
    int n_bad = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MD_CANCEL_EN
        .MD_Cancel(MD_Cancel),
`endif
        .MD_Start (MD_Start),
        .MD_Op    (MD_Op),
        .MD_A     (MD_A),
        .MD_B     (MD_B),
        .MD_Busy  (MD_Busy),
        .MD_HI    (MD_HI),
        .MD_LO    (MD_LO)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stall unit must never present a start while the unit is busy
    always @(posedge clk) begin
        if (reset && MD_Start && !MD_Cancel)
            assert (!MD_Busy) else $error("start presented while busy");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: effect of an operation on HI/LO, from the ISA rules
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Present a one-cycle start pulse; returns just after edge t0
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        MD_Start = 1'b1;
        MD_Op    = op;
        MD_A     = a;
        MD_B     = b;
        @(posedge clk);
        #1;
        MD_Start = 1'b0;
        MD_Op    = 3'd7;
    endtask

    // Issue an op and check busy length and resulting HI/LO
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          busy_cnt;
        int          exp_busy;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        bit          first;
        old_hi = m_hi;
        old_lo = m_lo;
        start_op(op, a, b);
        model_op(op, a, b);
        exp_busy = (op == OP_MULT || op == OP_MULTU) ? MULT_N :
                   (op == OP_DIV  || op == OP_DIVU)  ? DIV_N  : 0;
        busy_cnt = 0;
        first = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!MD_Busy) break;
            if (first) begin
                check({tag, "_old_hi"}, MD_HI, old_hi);
                check({tag, "_old_lo"}, MD_LO, old_lo);
                first = 1'b0;
            end
            busy_cnt++;
        end
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_hi"}, MD_HI, m_hi);
        check({tag, "_lo"}, MD_LO, m_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset     = 1'b0;
        MD_Cancel = 1'b0;
        MD_Start  = 1'b0;
        MD_Op     = 3'd7;
        MD_A      = 32'd0;
        MD_B      = 32'd0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, MD_Busy}, 32'd0);
        check("rst_hi", MD_HI, 32'd0);
        check("rst_lo", MD_LO, 32'd0);
        reset = 1'b1;

        // Directed test-plan cases
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg_hi_const", MD_HI, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", MD_LO, 32'hFFFF_FFFA);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", MD_HI, 32'hFFFF_FFFE);
        check("multu_max_lo_const", MD_LO, 32'h0000_0001);
        run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_lo_const", MD_LO, 32'hFFFF_FFFD);
        check("div_neg7_hi_const", MD_HI, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", MD_LO, 32'h8000_0000);
        check("div_ovf_hi_const", MD_HI, 32'd0);
        run_op("mthi", OP_MTHI, 32'h0000_1234, 32'd0);
        run_op("mtlo", OP_MTLO, 32'h0000_5678, 32'd0);
        run_op("divu_zero", OP_DIVU, 32'hDEAD_BEEF, 32'd0);
        check("divu_zero_hi_const", MD_HI, 32'h0000_1234);
        check("divu_zero_lo_const", MD_LO, 32'h0000_5678);
        run_op("div_zero", OP_DIV, 32'h8000_0001, 32'd0);
        run_op("op_none", 3'd7, 32'h1111_1111, 32'h2222_2222);
        run_op("op_rsvd", 3'd6, 32'h3333_3333, 32'h4444_4444);

        // Reset during cycle 3 of a div abandons it asynchronously
        start_op(OP_DIV, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("arst_busy", {31'd0, MD_Busy}, 32'd0);
        check("arst_hi", MD_HI, 32'd0);
        check("arst_lo", MD_LO, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op("post_rst_mult", OP_MULT, 32'd12345, 32'hFFFF_FF00);

`ifdef MD_CANCEL_EN
        // Cancel at cycle 2 of a mult, with a discarded mthi on the same edge
        run_op("pre_cancel_hi", OP_MTHI, 32'hAAAA_0001, 32'd0);
        run_op("pre_cancel_lo", OP_MTLO, 32'h5555_0002, 32'd0);
        start_op(OP_MULT, 32'd77, 32'd99);
        @(posedge clk);
        #1;
        MD_Cancel = 1'b1;
        MD_Start  = 1'b1;
        MD_Op     = OP_MTHI;
        MD_A      = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        MD_Cancel = 1'b0;
        MD_Start  = 1'b0;
        MD_Op     = 3'd7;
        @(negedge clk);
        check("cancel_busy", {31'd0, MD_Busy}, 32'd0);
        check("cancel_hi", MD_HI, m_hi);
        check("cancel_lo", MD_LO, m_lo);
        run_op("post_cancel_divu", OP_DIVU, 32'd1000, 32'd33);
`endif

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time guard
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
